// File: rtl/mouse_transmitter_pkg.sv
// mouse_pkg: shared definitions for the PS/2 host-to-device transmitter
// (and any receiver built alongside it).
//   state_e                  - transmitter FSM encoding (also exported on state_o)
//   ERR_NO_ACK_BIT           - ERROR_CODE bit set when the device does not ACK
//   ERR_TIMEOUT_BIT          - ERROR_CODE bit set when the watchdog aborts a frame
//   DEFAULT_CLK_HOLD_CYCLES  - clock-inhibit time before the start bit (120 us @ 50 MHz)
//   DEFAULT_TIMEOUT_CYCLES   - max wait per device clock edge (15 ms @ 50 MHz)
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD_CLK  = 3'd1,
    ST_START     = 3'd2,
    ST_SEND_BITS = 3'd3,
    ST_SEND_STOP = 3'd4,
    ST_WAIT_ACK  = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_e;

  localparam int ERR_NO_ACK_BIT  = 0;
  localparam int ERR_TIMEOUT_BIT = 1;

  localparam int DEFAULT_CLK_HOLD_CYCLES = 6000;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 750000;

  // PS/2 uses odd parity: the parity bit makes the count of ones in
  // data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/mouse_transmitter_if.sv
// mouse_transmitter_if: command-side bus between a host controller and the
// PS/2 transmitter.
//   SEND_BYTE     host -> tx  request strobe
//   BYTE_TO_SEND  host -> tx  command byte
//   BUSY          tx -> host  frame in progress
//   BYTE_SENT     tx -> host  one-cycle end-of-frame pulse
//   ERROR_CODE    tx -> host  {timeout, no_ack}, valid with BYTE_SENT
//
// Handshake: SEND_BYTE is the valid, ~BUSY is the ready. A request is
// accepted on a rising CLK edge where SEND_BYTE=1 and BUSY=0; BYTE_TO_SEND is
// captured on that same edge. SEND_BYTE while BUSY=1 is dropped, not queued.
// Completion is reported by BYTE_SENT (one cycle, BUSY falls in the same
// cycle); ERROR_CODE is held until the next accepted request.
interface mouse_transmitter_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BUSY;
  logic       BYTE_SENT;
  logic [1:0] ERROR_CODE;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND,
    input  BUSY, BYTE_SENT, ERROR_CODE
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND,
    output BUSY, BYTE_SENT, ERROR_CODE
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizer for an asynchronous PS/2 line plus a
// falling-edge pulse derived from the synchronized value.
//   clk_i   system clock
//   rst_n_i asynchronous active-low reset (flops reset to 1 = idle line)
//   line_i  raw pad value
//   sync_o  synchronized line
//   fall_o  one-cycle pulse on a synchronized 1->0 transition
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/mouse_transmitter.sv
// mouse_transmitter: PS/2 host-to-device frame transmitter (open-drain).
//   CLK, RESET         system clock, asynchronous active-low reset
//   CLK_MOUSE_IN       PS/2 clock pad value
//   DATA_MOUSE_IN      PS/2 data pad value
//   CLK_MOUSE_OUT_EN   1 = pull PS/2 clock low
//   DATA_MOUSE_OUT_EN  1 = pull PS/2 data low
//   host               mouse_transmitter_if.slave (SEND_BYTE/BYTE_TO_SEND in,
//                      BUSY/BYTE_SENT/ERROR_CODE out)
//   state_o            current FSM state for debug/observation
// Optional feature: define MOUSE_TX_TIMEOUT_EN to build the per-edge watchdog
// (ERROR_CODE[1]); without it the block waits indefinitely for device clocks.
module mouse_transmitter
  import mouse_pkg::*;
#(
  parameter int CLK_HOLD_CYCLES = DEFAULT_CLK_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   CLK_MOUSE_IN,
  input  logic   DATA_MOUSE_IN,
  output logic   CLK_MOUSE_OUT_EN,
  output logic   DATA_MOUSE_OUT_EN,
  mouse_transmitter_if.slave host,
  output state_e state_o
);

  localparam int HOLD_W = $clog2(CLK_HOLD_CYCLES + 1);

  state_e            state_q;
  logic              clk_en_q;
  logic              data_en_q;
  logic              busy_q;
  logic              sent_q;
  logic              no_ack_q;
  logic [7:0]        shift_q;
  logic              parity_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic              data_meta_q;
  logic              data_sync_q;

  logic clk_sync;
  logic clk_fall;

  ps2_sync_edge u_clk_sync (
    .clk_i   (CLK),
    .rst_n_i (RESET),
    .line_i  (CLK_MOUSE_IN),
    .sync_o  (clk_sync),
    .fall_o  (clk_fall)
  );

  // Data line only needs its level (ACK sample / idle check), no edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      data_meta_q <= DATA_MOUSE_IN;
      data_sync_q <= data_meta_q;
    end
  end

`ifdef MOUSE_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
  logic            wd_active;
  logic            wd_expire;

  // Watchdog runs only while the device owns the clock.
  assign wd_active = (state_q != ST_IDLE) && (state_q != ST_HOLD_CLK);
  assign wd_expire = wd_active && !clk_fall && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out; the parameter stays for a uniform instance
  // signature across builds.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      clk_en_q   <= 1'b0;
      data_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      no_ack_q   <= 1'b0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      hold_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
`ifdef MOUSE_TX_TIMEOUT_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      sent_q <= 1'b0;
`ifdef MOUSE_TX_TIMEOUT_EN
      if (!wd_active || clk_fall) wd_q <= '0;
      else                        wd_q <= wd_q + 1'b1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (host.SEND_BYTE) begin
            shift_q    <= host.BYTE_TO_SEND;
            parity_q   <= odd_parity(host.BYTE_TO_SEND);
            busy_q     <= 1'b1;
            no_ack_q   <= 1'b0;
`ifdef MOUSE_TX_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            hold_cnt_q <= '0;
            state_q    <= ST_HOLD_CLK;
          end
        end
        // Clock is pulled low from the first HOLD cycle for exactly
        // CLK_HOLD_CYCLES cycles; data joins on the last of them so the
        // start bit is already on the line when the clock is released.
        ST_HOLD_CLK: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_W'(CLK_HOLD_CYCLES)) begin
            clk_en_q <= 1'b0;
            state_q  <= ST_START;
          end else begin
            clk_en_q <= 1'b1;
            if (hold_cnt_q == HOLD_W'(CLK_HOLD_CYCLES - 1)) data_en_q <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_fall) begin
            data_en_q <= ~shift_q[0];
            bit_cnt_q <= 4'd0;
            state_q   <= ST_SEND_BITS;
          end
        end
        // shift_q[0] is the bit on the line; the next one is shift_q[1].
        ST_SEND_BITS: begin
          if (clk_fall) begin
            if (bit_cnt_q == 4'd7) begin
              data_en_q <= ~parity_q;
              bit_cnt_q <= 4'd8;
              state_q   <= ST_SEND_STOP;
            end else begin
              data_en_q <= ~shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_SEND_STOP: begin
          if (clk_fall) begin
            data_en_q <= 1'b0;
            state_q   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (clk_fall) begin
            no_ack_q <= data_sync_q;
            state_q  <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_sync && data_sync_q) begin
            busy_q  <= 1'b0;
            sent_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef MOUSE_TX_TIMEOUT_EN
      // Abort overrides whatever the state logic chose this cycle.
      if (wd_expire) begin
        clk_en_q  <= 1'b0;
        data_en_q <= 1'b0;
        busy_q    <= 1'b0;
        sent_q    <= 1'b1;
        timeout_q <= 1'b1;
        state_q   <= ST_IDLE;
      end
`endif
    end
  end

  always_comb begin
    host.ERROR_CODE                 = 2'b00;
    host.ERROR_CODE[ERR_NO_ACK_BIT] = no_ack_q;
`ifdef MOUSE_TX_TIMEOUT_EN
    host.ERROR_CODE[ERR_TIMEOUT_BIT] = timeout_q;
`else
    host.ERROR_CODE[ERR_TIMEOUT_BIT] = 1'b0;
`endif
  end

  assign host.BUSY         = busy_q;
  assign host.BYTE_SENT    = sent_q;
  assign CLK_MOUSE_OUT_EN  = clk_en_q;
  assign DATA_MOUSE_OUT_EN = data_en_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: a PS/2 device model on open-drain lines
// captures each frame; expected bytes come from a queue, parity from a
// ones-count, timing from the configured hold/timeout parameters.
module tb_mouse_transmitter;
  import mouse_pkg::*;

  localparam int HOLD = 50;
  localparam int TMO  = 1500;
  localparam int HALF = 20;

  logic   CLK = 1'b0;
  logic   RESET = 1'b0;
  logic   dev_clk = 1'b1;
  logic   dev_data = 1'b1;
  logic   clk_en;
  logic   data_en;
  logic   clk_line;
  logic   data_line;
  state_e state;

  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  logic [7:0] exp_q[$];

  mouse_transmitter_if bus();

  // Open-drain bus: either side may pull low.
  assign clk_line  = dev_clk & ~clk_en;
  assign data_line = dev_data & ~data_en;

  mouse_transmitter #(.CLK_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CLK_MOUSE_IN      (clk_line),
    .DATA_MOUSE_IN     (data_line),
    .CLK_MOUSE_OUT_EN  (clk_en),
    .DATA_MOUSE_OUT_EN (data_en),
    .host              (bus),
    .state_o           (state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (bus.BYTE_SENT === 1'b1) sent_cnt++;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic request(input logic [7:0] b);
    @(negedge CLK);
    bus.SEND_BYTE    = 1'b1;
    bus.BYTE_TO_SEND = b;
    @(negedge CLK);
    bus.SEND_BYTE    = 1'b0;
  endtask

  // Waits (bounded) until the host has held and then released the clock.
  task automatic wait_release(output int rel);
    int lat;
    int held;
    lat = 0; held = 0; rel = -1;
    while (rel < 0 && lat < HOLD + 20) begin
      @(negedge CLK);
      lat++;
      if (clk_en === 1'b1) held++;
      else if (held > 0) rel = lat;
    end
  endtask

  // Device side of one host-to-device frame: 11 clock pulses, data sampled
  // at each rising edge, ACK driven on the 11th pulse when requested.
  task automatic dev_frame(input bit ack, output logic [7:0] got,
                           output logic par, output logic stp);
    got = 8'hxx; par = 1'bx; stp = 1'bx;
    repeat (HALF) @(negedge CLK);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK);
      if (i <= 8)       got[i-1] = data_line;
      else if (i == 9)  par = data_line;
      else if (i == 10) stp = data_line;
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
      if (i < 11) repeat (HALF) @(negedge CLK);
    end
  endtask

  // Full request + frame + completion with inline checks.
  task automatic run_frame(input logic [7:0] b, input bit ack,
                           input bit intrude, input logic [7:0] intr_b);
    int lat, hold_n, rel_lat, base, n;
    logic last_data, prev_data, got_par, got_stp, exp_par;
    logic [7:0] got, exp_b;
    logic [1:0] exp_err;
    base = sent_cnt;
    exp_q.push_back(b);
    request(b);
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++; $display("FAIL busy_after_req: got %b want 1", bus.BUSY);
    end
    lat = 0; hold_n = 0; rel_lat = -1; last_data = 1'bx; prev_data = 1'bx;
    while (rel_lat < 0 && lat < HOLD + 20) begin
      if (intrude && lat == 10) begin
        bus.SEND_BYTE = 1'b1; bus.BYTE_TO_SEND = intr_b;
      end
      if (lat == 11) bus.SEND_BYTE = 1'b0;
      @(negedge CLK);
      lat++;
      if (clk_en === 1'b1) begin
        hold_n++;
        if (lat == HOLD)     last_data = data_en;
        if (lat == HOLD - 1) prev_data = data_en;
      end else if (hold_n > 0) rel_lat = lat;
    end
    checks++;
    if (hold_n != HOLD) begin
      errors++; $display("FAIL hold_cycles: got %0d want %0d", hold_n, HOLD);
    end
    checks++;
    if (rel_lat != HOLD + 1) begin
      errors++; $display("FAIL release_latency: got %0d want %0d", rel_lat, HOLD + 1);
    end
    checks++;
    if (last_data !== 1'b1 || prev_data !== 1'b0) begin
      errors++; $display("FAIL data_on_last_hold: last %b prev %b want 1 0", last_data, prev_data);
    end
    checks++;
    if (data_line !== 1'b0) begin
      errors++; $display("FAIL start_bit: got %b want 0", data_line);
    end
    dev_frame(ack, got, got_par, got_stp);
    exp_b   = exp_q.pop_front();
    exp_par = ($countones(exp_b) % 2 == 0) ? 1'b1 : 1'b0;
    exp_err = ack ? 2'b00 : 2'b01;
    checks++;
    if (got !== exp_b) begin
      errors++; $display("FAIL frame_byte: got %h want %h", got, exp_b);
    end
    checks++;
    if (got_par !== exp_par) begin
      errors++; $display("FAIL parity: got %b want %b (byte %h)", got_par, exp_par, exp_b);
    end
    checks++;
    if (got_stp !== 1'b1) begin
      errors++; $display("FAIL stop_bit: got %b want 1", got_stp);
    end
    n = 0;
    while (bus.BYTE_SENT !== 1'b1 && n < 200) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (bus.BYTE_SENT !== 1'b1) begin
      errors++; $display("FAIL byte_sent_seen: no pulse within %0d cycles", n);
    end
    checks++;
    if (bus.ERROR_CODE !== exp_err || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL done_status: err %b busy %b want err %b busy 0",
                         bus.ERROR_CODE, bus.BUSY, exp_err);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (sent_cnt != base + 1) begin
      errors++; $display("FAIL sent_count: got %0d want %0d", sent_cnt - base, 1);
    end
    checks++;
    if (bus.ERROR_CODE !== exp_err || clk_en !== 1'b0 || data_en !== 1'b0) begin
      errors++; $display("FAIL idle_after: err %b clk_en %b data_en %b want %b 0 0",
                         bus.ERROR_CODE, clk_en, data_en, exp_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (clk_en !== 1'b0 || data_en !== 1'b0 || bus.BUSY !== 1'b0 ||
        bus.BYTE_SENT !== 1'b0 || bus.ERROR_CODE !== 2'b00 || state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: clk_en %b data_en %b busy %b sent %b err %b",
                         clk_en, data_en, bus.BUSY, bus.BYTE_SENT, bus.ERROR_CODE);
    end
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_basic;
    run_frame(8'hF4, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_parity;
    run_frame(8'h00, 1'b1, 1'b0, 8'h00);
    run_frame(8'hFF, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_no_ack;
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back;
    run_frame(8'hAA, 1'b1, 1'b1, 8'h55);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++)
      run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid;
    int rel, base;
    base = sent_cnt;
    request(8'hE8);
    wait_release(rel);
    checks++;
    if (rel != HOLD + 1) begin
      errors++; $display("FAIL mid_release: got %0d want %0d", rel, HOLD + 1);
    end
    repeat (HALF) @(negedge CLK);
    for (int i = 1; i <= 4; i++) begin
      dev_clk = 1'b0; repeat (HALF) @(negedge CLK);
      dev_clk = 1'b1; repeat (HALF) @(negedge CLK);
    end
    dev_clk = 1'b0;
    repeat (HALF / 2) @(negedge CLK);
    // D4 of 0xE8 is 0, so the host should be pulling data low here.
    checks++;
    if (data_en !== 1'b1) begin
      errors++; $display("FAIL d4_driven: got %b want 1", data_en);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (clk_en !== 1'b0 || data_en !== 1'b0 || bus.BUSY !== 1'b0 || bus.BYTE_SENT !== 1'b0) begin
      errors++; $display("FAIL reset_mid: clk_en %b data_en %b busy %b sent %b want 0 0 0 0",
                         clk_en, data_en, bus.BUSY, bus.BYTE_SENT);
    end
    dev_clk = 1'b1;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (sent_cnt != base) begin
      errors++; $display("FAIL reset_no_sent: got %0d pulses want 0", sent_cnt - base);
    end
    run_frame(8'hF4, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_timeout;
    int rel, base, n;
    base = sent_cnt;
    request(8'h3C);
    wait_release(rel);
    checks++;
    if (rel != HOLD + 1) begin
      errors++; $display("FAIL tmo_release: got %0d want %0d", rel, HOLD + 1);
    end
`ifdef MOUSE_TX_TIMEOUT_EN
    n = 0;
    while (bus.BYTE_SENT !== 1'b1 && n < TMO + 100) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (n < TMO - 2 || n > TMO + 2) begin
      errors++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO);
    end
    checks++;
    if (bus.ERROR_CODE !== 2'b10 || clk_en !== 1'b0 || data_en !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL tmo_status: err %b clk_en %b data_en %b busy %b want 10 0 0 0",
                         bus.ERROR_CODE, clk_en, data_en, bus.BUSY);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (sent_cnt != base + 1) begin
      errors++; $display("FAIL tmo_sent_count: got %0d want 1", sent_cnt - base);
    end
`else
    n = 0;
    repeat (TMO + 100) @(negedge CLK);
    checks++;
    if (bus.BUSY !== 1'b1 || sent_cnt != base || bus.ERROR_CODE !== 2'b00 ||
        clk_en !== 1'b0 || data_en !== 1'b1) begin
      errors++; $display("FAIL no_watchdog_wait: busy %b sent %0d err %b clk_en %b data_en %b",
                         bus.BUSY, sent_cnt - base, bus.ERROR_CODE, clk_en, data_en);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (data_en !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL recover_reset: data_en %b busy %b want 0 0", data_en, bus.BUSY);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.SEND_BYTE    = 1'b0;
    bus.BYTE_TO_SEND = 8'h00;
    test_reset;
    test_basic;
    test_parity;
    test_no_ack;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_timeout;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
